// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and bit-period derivation.
// Used by both uart_tx and uart_rx so both ends agree on framing.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Truncating divide: any fractional remainder becomes baud-rate error.
    function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter for the UART; cleared when a frame is accepted,
// emits a one-cycle tick on the last cycle of every bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_rate
            $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 12000000,
    parameter int BAUD_RATE       = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);

    uart_state_t          state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [2:0]           idx, idx_n;
    logic                 tx_n, busy_n, done_n;
    logic                 clear;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            idx   <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            idx   <= idx_n;
            tx    <= tx_n;
            busy  <= busy_n;
            done  <= done_n;
`ifdef UART_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // Next-state logic computes the value each output register takes at the coming edge.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;
        clear   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (start) begin
                    state_n = ST_START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    shreg_n = data;
                    idx_n   = '0;
                    clear   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^data;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n = ST_DATA;
                    tx_n    = shreg[0];
                    shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                    idx_n   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_n = ST_PARITY;
                        tx_n    = par;
`else
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        idx_n   = idx + 3'd1;
                        tx_n    = shreg[0];
                        shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_n = ST_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_n = ST_IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 12 MHz / 9600 baud; decodes the serial line mid-bit.
// Honours UART_TX_PARITY_EN for frame length and parity-bit checks.
module tb_uart_tx;

    localparam int C = 1250;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       start = 1'b0;
    logic       tx, busy, done;

    int checks = 0;
    int failures = 0;

    uart_tx #(
        .CLOCK_FREQUENCY(12000000),
        .BAUD_RATE      (9600)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .start(start),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the accepting posedge (cycle j=0 of the frame).
    // inj_j >= 0 pulses start with 0x00 at that cycle; chain launches next_byte in the done cycle.
    task automatic check_frame(input string tag, input logic [7:0] exp_byte,
                               input int inj_j, input bit chain, input logic [7:0] next_byte);
        logic [NBITS-1:0] bits;
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic tx_first;
        bits = '0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        tx_first = tx;
        for (int j = 0; j <= FRAME; j++) begin
            if (j > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = j;
            end
            if (j < FRAME && (j % C) == C / 2) bits[j / C] = tx;
            if (j == inj_j) begin
                data = 8'h00;
                start = 1'b1;
            end else if (j == inj_j + 1) begin
                start = 1'b0;
            end
            if (j == FRAME && chain) begin
                data = next_byte;
                start = 1'b1;
            end
        end
        chk({tag, "_tx_fall"}, 32'(tx_first), 32'd0);
        chk({tag, "_startbit"}, 32'(bits[0]), 32'd0);
        chk({tag, "_data"}, 32'(bits[8:1]), 32'(exp_byte));
`ifdef UART_TX_PARITY_EN
        chk({tag, "_parity"}, 32'(bits[9]), 32'(^exp_byte));
`endif
        chk({tag, "_stopbit"}, 32'(bits[NBITS-1]), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(FRAME));
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_pos"}, 32'(done_at), 32'(FRAME));
    endtask

    // Drives start for exactly one posedge; returns at the negedge of frame cycle 0.
    task automatic launch(input logic [7:0] d);
        @(negedge clk);
        data = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data = 8'hXX;
    endtask

    initial begin
        int bad_tx, bad_busy, bad_done;

        // Test 1: reset and idle
        rst = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad_tx = 0;
        bad_busy = 0;
        bad_done = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (done !== 1'b0) bad_done++;
        end
        chk("idle_tx_glitches", 32'(bad_tx), 32'd0);
        chk("idle_busy_glitches", 32'(bad_busy), 32'd0);
        chk("idle_done_glitches", 32'(bad_done), 32'd0);

        // Test 2: 0x55
        launch(8'h55);
        check_frame("f55", 8'h55, -1, 1'b0, 8'h00);
        @(negedge clk);
        chk("after55_tx", 32'(tx), 32'd1);

        // Test 3: start pulse with 0x00 while busy is ignored
        launch(8'hC3);
        check_frame("ignore", 8'hC3, 3000, 1'b0, 8'h00);
        repeat (C) @(negedge clk);
        chk("ignore_no_relaunch", 32'({tx, busy}), 32'b10);

        // Test 4: back-to-back 0x00 then 0xFF, second start in the done cycle
        launch(8'h00);
        check_frame("b2b0", 8'h00, -1, 1'b1, 8'hFF);
        @(negedge clk);
        start = 1'b0;
        check_frame("b2b1", 8'hFF, -1, 1'b0, 8'h00);

        // Test 5: reset mid-DATA aborts the frame
        launch(8'hA5);
        repeat (3 * C + 200) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad_tx = 0;
        bad_done = 0;
        for (int i = 0; i < 2 * C; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (done !== 1'b0) bad_done++;
        end
        chk("abort_line_idle", 32'(bad_tx), 32'd0);
        chk("abort_no_done", 32'(bad_done), 32'd0);

        // Test 6: clean frame 0xA5 after the abort
        launch(8'hA5);
        check_frame("fA5", 8'hA5, -1, 1'b0, 8'h00);
`ifdef UART_TX_PARITY_EN
        launch(8'h07);
        check_frame("f07", 8'h07, -1, 1'b0, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
